mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage between exe_stage and wb_stage. Holds one instruction, waits for the SRAM-like data_data_ok when a load/store was issued in EXE, and aligns/extends load data.
//  Produces ms_to_ws_bus {gr_we[72:69], dest[68:64], result[63:32], pc[31:0]} and passes ms_ex_bus through. Discards stale data_ok responses after a flush.
// PARAMETERS
//  ES_TO_MS_WD 111  {ld_op[110:108],addr_lo[107:106],rt_val[105:74],req[73],gr_we[72:69],dest[68:64],alu_res[63:32],pc[31:0]}
//  EX_WD       47   exception bus width (10 flags, 5-bit c0 addr, 32-bit badvaddr), opaque here
//  MAX_OUTST   3    max stale responses counted after flush; counter width 2
// PORTS
//  clk             in   1    clock
//  resetn          in   1    async reset, active-low
//  es_to_ms_valid  in   1    EXE holds valid instruction
//  es_to_ms_bus    in   111  EXE payload
//  es_ex_bus       in   47   EXE exception bus
//  ms_allowin      out  1    MEM can accept this cycle
//  ms_to_ws_valid  out  1    MEM presents a completed instruction
//  ms_to_ws_bus    out  73   to wb_stage
//  ms_ex_bus       out  47   registered copy of es_ex_bus
//  ws_allowin      in   1    WB can accept
//  data_data_ok    in   1    data SRAM response strobe
//  data_rdata      in   32   data SRAM read data
//  flush           in   1    CP0 exception/eret flush
//  ms_write_reg    out  1    valid & gr_we!=0 (stall detection)
//  ms_reg_dest     out  5    dest
//  ms_ex           out  1    valid & any flag in ms_ex_bus set (kills EXE request issue)
// BEHAVIOUR
//  - Async reset: ms_valid=0, state=IDLE, discard_cnt=0, buffers=0. All outputs 0 except ms_allowin=1.
//  - Load: es_to_ms_valid & ms_allowin & !flush. Captures both buses; state=WAIT if req=1 and no exception flag set, else DONE.
//  - States IDLE(empty), WAIT(awaiting data_ok), DONE(result ready).
//    IDLE->WAIT/DONE on load. WAIT->DONE on data_data_ok while discard_cnt==0 (data_rdata captured).
//    DONE->IDLE on ms_to_ws_valid & ws_allowin with no new load; a simultaneous load goes straight to WAIT/DONE.
//  - ms_ready_go = (state==DONE); ms_to_ws_valid = ms_valid & ms_ready_go & !flush.
//  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
//  - Latency: non-memory instr 1 cycle. Load: 1 cycle after data_ok. data_ok in the cycle of entry is legal and is captured.
//  - Flush: ms_valid<=0, state<=IDLE. If state was WAIT, discard_cnt++ (saturates at MAX_OUTST).
//    data_ok while discard_cnt>0: discard_cnt-- and the data is dropped; a live WAIT instr does not complete on it.
//    Flush and data_ok in the same cycle with state WAIT: net discard_cnt unchanged, response dropped.
//  - Load align by addr_lo (ld_op: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lwl, 6 lwr):
//    lb/lbu: byte[addr_lo], sign/zero-extend.
//    lh/lhu: half[addr_lo[1]], sign/zero-extend; lw: rdata.
//    lwl: merge rdata << 8*(3-addr_lo) into rt_val, upper bytes. lwr: rdata >> 8*addr_lo, lower bytes.
//    gr_we is passed unchanged (EXE computes the byte mask).
//  - Stores (req=1, gr_we=0) also wait for data_ok; result=alu_res. Non-memory result=alu_res.
//  - ms_ex_bus is registered on load and zeroed on flush. Instructions with an exception never wait.
// CONFIGURATION
//  MS_FWD_EN defined: extra outputs ms_fwd_valid (1) = ms_valid & state==DONE & gr_we!=0, and ms_fwd_data (32) = final result, for EXE/ID bypass.
//  MS_FWD_EN undefined: ports absent; consumers stall on ms_write_reg/ms_reg_dest only.
// TESTING
//  1) ALU op pc=0xBFC00000, req=0, alu_res=5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, bus result=5.
//  2) lb addr_lo=2, data_ok 3 cycles later, rdata=0x12807F00 -> result 0xFFFFFF80, valid 1 cycle after data_ok.
//  3) lwr addr_lo=1, rt_val=0xAABBCCDD, rdata=0x11223344 -> result 0xAA112233.
//  4) Load in WAIT, flush=1; next load issued; first data_ok(0xDEAD) dropped; second data_ok(0x1234) -> result 0x1234.
//  5) ws_allowin=0 with DONE -> ms_allowin=0, bus held stable; no new load until ws_allowin=1.
//  6) resetn low mid-WAIT -> all outputs 0, ms_allowin=1, discard_cnt=0 immediately (async).

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; waits for data_data_ok, aligns load data, drops stale responses after a flush.
// Optional bypass outputs ms_fwd_valid/ms_fwd_data are built when MS_FWD_EN is defined.
module mem_stage #(
  parameter int unsigned ES_TO_MS_WD = 111,
  parameter int unsigned MS_TO_WS_WD = 73,
  parameter int unsigned EX_WD       = 47,
  parameter int unsigned MAX_OUTST   = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   es_to_ms_valid,
  input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
  input  logic [EX_WD-1:0]       es_ex_bus,
  output logic                   ms_allowin,
  output logic                   ms_to_ws_valid,
  output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
  output logic [EX_WD-1:0]       ms_ex_bus,
  input  logic                   ws_allowin,
  input  logic                   data_data_ok,
  input  logic [31:0]            data_rdata,
  input  logic                   flush,
`ifdef MS_FWD_EN
  output logic                   ms_fwd_valid,
  output logic [31:0]            ms_fwd_data,
`endif
  output logic                   ms_write_reg,
  output logic [4:0]             ms_reg_dest,
  output logic                   ms_ex
);

  localparam int unsigned CNT_W    = 2;
  localparam int unsigned EX_FLAGS = 10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] discard_cnt, discard_cnt_nxt;
  logic             ms_valid;
  logic [2:0]       ld_op_r;
  logic [1:0]       addr_lo_r;
  logic [31:0]      rt_val_r;
  logic [3:0]       gr_we_r;
  logic [4:0]       dest_r;
  logic [31:0]      result_r;
  logic [31:0]      pc_r;
  logic [EX_WD-1:0] ex_bus_r;

  logic        ms_ready_go;
  logic        load_fire;
  logic        es_req;
  logic        es_ex_any;
  logic        data_ok_live;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [4:0]  sh_l;
  logic [4:0]  sh_r;
  logic [31:0] ld_aligned;

  assign es_req       = es_to_ms_bus[73];
  assign es_ex_any    = |es_ex_bus[EX_WD-1 -: EX_FLAGS];
  assign ms_ready_go  = (state == S_DONE);
  assign ms_allowin   = !ms_valid || (ms_ready_go && ws_allowin);
  assign load_fire    = es_to_ms_valid && ms_allowin && !flush;
  assign data_ok_live = data_data_ok && (discard_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      discard_cnt <= '0;
    end else begin
      state       <= state_nxt;
      discard_cnt <= discard_cnt_nxt;
    end
  end

  // Next state and stale-response bookkeeping
  always_comb begin
    state_nxt       = state;
    discard_cnt_nxt = discard_cnt;
    if (flush) begin
      state_nxt = S_IDLE;
    end else if (load_fire) begin
      state_nxt = (es_req && !es_ex_any) ? S_WAIT : S_DONE;
    end else begin
      case (state)
        S_WAIT:  if (data_ok_live) state_nxt = S_DONE;
        S_DONE:  if (ms_to_ws_valid && ws_allowin) state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
    // A response arriving with the flush of a waiting instr cancels the new stale entry
    if (flush && state == S_WAIT) begin
      if (!data_data_ok && discard_cnt != CNT_W'(MAX_OUTST))
        discard_cnt_nxt = discard_cnt + CNT_W'(1);
    end else if (data_data_ok && discard_cnt != '0) begin
      discard_cnt_nxt = discard_cnt - CNT_W'(1);
    end
  end

  // Load data alignment and extension
  always_comb begin
    sh_l    = {~addr_lo_r, 3'b000};
    sh_r    = {addr_lo_r, 3'b000};
    ld_half = addr_lo_r[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (addr_lo_r)
      2'd0:    ld_byte = data_rdata[7:0];
      2'd1:    ld_byte = data_rdata[15:8];
      2'd2:    ld_byte = data_rdata[23:16];
      default: ld_byte = data_rdata[31:24];
    endcase
    case (ld_op_r)
      LD_LB:   ld_aligned = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_aligned = {24'd0, ld_byte};
      LD_LH:   ld_aligned = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ld_aligned = {16'd0, ld_half};
      LD_LWL:  ld_aligned = (data_rdata << sh_l) | (rt_val_r & ~(ALL_ONES << sh_l));
      LD_LWR:  ld_aligned = (data_rdata >> sh_r) | (rt_val_r & ~(ALL_ONES >> sh_r));
      default: ld_aligned = data_rdata;
    endcase
  end

  // Instruction buffer; stores (gr_we==0) keep alu_res when their response arrives
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid  <= 1'b0;
      ld_op_r   <= '0;
      addr_lo_r <= '0;
      rt_val_r  <= '0;
      gr_we_r   <= '0;
      dest_r    <= '0;
      result_r  <= '0;
      pc_r      <= '0;
      ex_bus_r  <= '0;
    end else begin
      if (flush)
        ms_valid <= 1'b0;
      else if (ms_allowin)
        ms_valid <= es_to_ms_valid;

      if (flush) begin
        ex_bus_r <= '0;
      end else if (load_fire) begin
        ld_op_r   <= es_to_ms_bus[110:108];
        addr_lo_r <= es_to_ms_bus[107:106];
        rt_val_r  <= es_to_ms_bus[105:74];
        gr_we_r   <= es_to_ms_bus[72:69];
        dest_r    <= es_to_ms_bus[68:64];
        result_r  <= es_to_ms_bus[63:32];
        pc_r      <= es_to_ms_bus[31:0];
        ex_bus_r  <= es_ex_bus;
      end else if (state == S_WAIT && data_ok_live && gr_we_r != 4'd0) begin
        result_r <= ld_aligned;
      end
    end
  end

  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
  assign ms_to_ws_bus   = {gr_we_r, dest_r, result_r, pc_r};
  assign ms_ex_bus      = ex_bus_r;
  assign ms_write_reg   = ms_valid && (gr_we_r != 4'd0);
  assign ms_reg_dest    = dest_r;
  assign ms_ex          = ms_valid && (|ex_bus_r[EX_WD-1 -: EX_FLAGS]);

`ifdef MS_FWD_EN
  assign ms_fwd_valid = ms_valid && ms_ready_go && (gr_we_r != 4'd0);
  assign ms_fwd_data  = result_r;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors with a scoreboard queue drained by an independent output monitor.
module tb_mem_stage;

  logic          clk = 1'b0;
  logic          resetn;
  logic          es_to_ms_valid;
  logic [110:0]  es_to_ms_bus;
  logic [46:0]   es_ex_bus;
  logic          ms_allowin;
  logic          ms_to_ws_valid;
  logic [72:0]   ms_to_ws_bus;
  logic [46:0]   ms_ex_bus;
  logic          ws_allowin;
  logic          data_data_ok;
  logic [31:0]   data_rdata;
  logic          flush;
  logic          ms_write_reg;
  logic [4:0]    ms_reg_dest;
  logic          ms_ex;
`ifdef MS_FWD_EN
  logic          ms_fwd_valid;
  logic [31:0]   ms_fwd_data;
`endif

  int checks = 0;
  int errors = 0;
  logic [72:0] exp_q[$];

  localparam logic [2:0] LW = 3'd0, LB = 3'd1, LBU = 3'd2, LH = 3'd3, LHU = 3'd4, LWL = 3'd5, LWR = 3'd6;

  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus), .es_ex_bus(es_ex_bus),
    .ms_allowin(ms_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ms_ex_bus(ms_ex_bus), .ws_allowin(ws_allowin),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .flush(flush),
`ifdef MS_FWD_EN
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_data(ms_fwd_data),
`endif
    .ms_write_reg(ms_write_reg), .ms_reg_dest(ms_reg_dest), .ms_ex(ms_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [110:0] mk(input logic [2:0] op, input logic [1:0] al, input logic [31:0] rt,
                                      input logic req, input logic [3:0] we, input logic [4:0] d,
                                      input logic [31:0] alu, input logic [31:0] pc);
    return {op, al, rt, req, we, d, alu, pc};
  endfunction

  function automatic logic [72:0] wb(input logic [3:0] we, input logic [4:0] d,
                                     input logic [31:0] res, input logic [31:0] pc);
    return {we, d, res, pc};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one instruction and hold it until MEM accepts it (bounded)
  task automatic send(input logic [110:0] b, input logic [46:0] ex);
    int n;
    n = 0;
    es_to_ms_bus = b; es_ex_bus = ex; es_to_ms_valid = 1'b1;
    #1;
    while (!ms_allowin && n < 50) begin @(posedge clk); #1; n++; end
    if (!ms_allowin) chk("send_timeout", 73'(ms_allowin), 73'(1));
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0; es_ex_bus = '0;
  endtask

  task automatic resp(input logic [31:0] d);
    data_data_ok = 1'b1; data_rdata = d;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
  endtask

  task automatic do_flush(input logic with_ok, input logic [31:0] d);
    flush = 1'b1; data_data_ok = with_ok; data_rdata = d;
    @(posedge clk); #1;
    flush = 1'b0; data_data_ok = 1'b0;
  endtask

  // Monitor: every accepted output must match the head of the scoreboard
  always @(negedge clk) begin
    if (resetn && ms_to_ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ws_bus_unexpected actual=%h expected=none", ms_to_ws_bus);
      end else begin
        chk("ws_bus", ms_to_ws_bus, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [110:0] b;
    logic [46:0]  exv;
    int n;
    resetn = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; es_ex_bus = '0;
    ws_allowin = 1'b1; data_data_ok = 1'b0; data_rdata = '0; flush = 1'b0;
    tick(2);
    chk("rst_allowin", 73'(ms_allowin), 73'(1));
    chk("rst_valid", 73'(ms_to_ws_valid), 73'(0));
    chk("rst_bus", ms_to_ws_bus, 73'(0));
    chk("rst_write_reg", 73'(ms_write_reg), 73'(0));
    resetn = 1'b1;
    tick(1);

    // ALU op completes one cycle after entry
    exp_q.push_back(wb(4'hF, 5'd2, 32'd5, 32'hBFC0_0000));
    send(mk(LW, 2'd0, 32'd0, 1'b0, 4'hF, 5'd2, 32'd5, 32'hBFC0_0000), '0);
    #1;
    chk("alu_valid", 73'(ms_to_ws_valid), 73'(1));
    chk("alu_write_reg", 73'(ms_write_reg), 73'(1));
    chk("alu_dest", 73'(ms_reg_dest), 73'(2));
    tick(1);

    // lb with data_ok three cycles after entry
    exp_q.push_back(wb(4'hF, 5'd3, 32'hFFFF_FF80, 32'hBFC0_0004));
    send(mk(LB, 2'd2, 32'd0, 1'b1, 4'hF, 5'd3, 32'h1000_0002, 32'hBFC0_0004), '0);
    tick(2);
    chk("lb_wait_valid", 73'(ms_to_ws_valid), 73'(0));
    resp(32'h1280_7F00);
    chk("lb_done_valid", 73'(ms_to_ws_valid), 73'(1));
    tick(1);

    // lwr, lwl, lh, lhu, lbu, lw each with data_ok in the entry cycle
    exp_q.push_back(wb(4'h7, 5'd4, 32'hAA11_2233, 32'hBFC0_0008));
    send(mk(LWR, 2'd1, 32'hAABB_CCDD, 1'b1, 4'h7, 5'd4, 32'h0, 32'hBFC0_0008), '0);
    resp(32'h1122_3344);
    exp_q.push_back(wb(4'hC, 5'd5, 32'h3344_CCDD, 32'hBFC0_000C));
    send(mk(LWL, 2'd1, 32'hAABB_CCDD, 1'b1, 4'hC, 5'd5, 32'h0, 32'hBFC0_000C), '0);
    resp(32'h1122_3344);
    exp_q.push_back(wb(4'hF, 5'd6, 32'hFFFF_8001, 32'hBFC0_0010));
    send(mk(LH, 2'd2, 32'h0, 1'b1, 4'hF, 5'd6, 32'h0, 32'hBFC0_0010), '0);
    resp(32'h8001_0000);
    exp_q.push_back(wb(4'hF, 5'd7, 32'h0000_8765, 32'hBFC0_0014));
    send(mk(LHU, 2'd0, 32'h0, 1'b1, 4'hF, 5'd7, 32'h0, 32'hBFC0_0014), '0);
    resp(32'h1234_8765);
    exp_q.push_back(wb(4'hF, 5'd8, 32'h0000_00F0, 32'hBFC0_0018));
    send(mk(LBU, 2'd1, 32'h0, 1'b1, 4'hF, 5'd8, 32'h0, 32'hBFC0_0018), '0);
    resp(32'h0000_F000);
    // Store waits for data_ok but keeps alu_res
    exp_q.push_back(wb(4'h0, 5'd0, 32'h0000_0100, 32'hBFC0_001C));
    send(mk(LW, 2'd0, 32'h0, 1'b1, 4'h0, 5'd0, 32'h0000_0100, 32'hBFC0_001C), '0);
    chk("st_wait_valid", 73'(ms_to_ws_valid), 73'(0));
    resp(32'h0000_FFFF);
    tick(1);

    // Exception instr never waits, even with req set
    exv = {10'b00_0000_0001, 5'd13, 32'hBFC0_0100};
    exp_q.push_back(wb(4'hF, 5'd9, 32'h0000_0077, 32'hBFC0_0020));
    send(mk(LW, 2'd0, 32'h0, 1'b1, 4'hF, 5'd9, 32'h0000_0077, 32'hBFC0_0020), exv);
    #1;
    chk("ex_flag", 73'(ms_ex), 73'(1));
    chk("ex_bus", 73'(ms_ex_bus), 73'(exv));
    chk("ex_valid", 73'(ms_to_ws_valid), 73'(1));
    tick(1);

    // Flush mid-WAIT: the next response is stale and must be dropped
    send(mk(LW, 2'd0, 32'h0, 1'b1, 4'hF, 5'd10, 32'h0, 32'hBFC0_0024), '0);
    do_flush(1'b0, 32'h0);
    #1;
    chk("flush_valid", 73'(ms_to_ws_valid), 73'(0));
    chk("flush_allowin", 73'(ms_allowin), 73'(1));
    chk("flush_ex_bus", 73'(ms_ex_bus), 73'(0));
    exp_q.push_back(wb(4'hF, 5'd11, 32'h0000_1234, 32'hBFC0_0028));
    send(mk(LW, 2'd0, 32'h0, 1'b1, 4'hF, 5'd11, 32'h0, 32'hBFC0_0028), '0);
    resp(32'h0000_DEAD);
    chk("stale_valid", 73'(ms_to_ws_valid), 73'(0));
    resp(32'h0000_1234);
    tick(1);

    // Flush and data_ok together in WAIT: response dropped, no extra stale count
    send(mk(LW, 2'd0, 32'h0, 1'b1, 4'hF, 5'd12, 32'h0, 32'hBFC0_002C), '0);
    do_flush(1'b1, 32'h0000_BEEF);
    exp_q.push_back(wb(4'hF, 5'd13, 32'h0000_0077, 32'hBFC0_0030));
    send(mk(LW, 2'd0, 32'h0, 1'b1, 4'hF, 5'd13, 32'h0, 32'hBFC0_0030), '0);
    resp(32'h0000_0077);
    chk("flush_ok_valid", 73'(ms_to_ws_valid), 73'(1));
    tick(1);

    // Back-pressure: DONE holds, bus stable, next instr waits for ws_allowin
    ws_allowin = 1'b0;
    exp_q.push_back(wb(4'hF, 5'd14, 32'hCAFE_0001, 32'hBFC0_0034));
    send(mk(LW, 2'd0, 32'h0, 1'b0, 4'hF, 5'd14, 32'hCAFE_0001, 32'hBFC0_0034), '0);
    es_to_ms_bus = mk(LW, 2'd0, 32'h0, 1'b0, 4'hF, 5'd15, 32'hCAFE_0002, 32'hBFC0_0038);
    es_to_ms_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_allowin", 73'(ms_allowin), 73'(0));
      chk("bp_bus", ms_to_ws_bus, wb(4'hF, 5'd14, 32'hCAFE_0001, 32'hBFC0_0034));
      tick(1);
    end
    exp_q.push_back(wb(4'hF, 5'd15, 32'hCAFE_0002, 32'hBFC0_0038));
    ws_allowin = 1'b1;
    tick(1);
    es_to_ms_valid = 1'b0;
    tick(2);

    // Async reset mid-WAIT with a stale response pending
    send(mk(LW, 2'd0, 32'h0, 1'b1, 4'hF, 5'd16, 32'h0, 32'hBFC0_003C), '0);
    do_flush(1'b0, 32'h0);
    send(mk(LW, 2'd0, 32'h0, 1'b1, 4'hF, 5'd17, 32'h0, 32'hBFC0_0040), '0);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 73'(ms_to_ws_valid), 73'(0));
    chk("arst_allowin", 73'(ms_allowin), 73'(1));
    chk("arst_bus", ms_to_ws_bus, 73'(0));
    chk("arst_write_reg", 73'(ms_write_reg), 73'(0));
    chk("arst_dest", 73'(ms_reg_dest), 73'(0));
    @(posedge clk); #1;
    resetn = 1'b1;
    tick(1);
    exp_q.push_back(wb(4'hF, 5'd18, 32'h5555_AAAA, 32'hBFC0_0044));
    send(mk(LW, 2'd0, 32'h0, 1'b1, 4'hF, 5'd18, 32'h0, 32'hBFC0_0044), '0);
    resp(32'h5555_AAAA);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(1); n++; end
    chk("scoreboard_drained", 73'(exp_q.size()), 73'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
